// File: rtl/key_ctrl_pkg.sv
// Shared types and defaults for the key unlock controller.
// States of the attempt FSM plus default key width, key and fail limit.
package key_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_APPLY,
    ST_LOCKOUT
  } key_state_t;

  localparam int         KEY_W_DEF      = 8;
  localparam logic [7:0] GOLDEN_KEY_DEF = 8'hA5;
  localparam int         MAX_FAIL_DEF   = 3;

endpackage

// File: rtl/key_shifter.sv
// Serial-to-parallel key capture: MSB-first shift register and bit counter.
// Ports: clk, rst, clr (load-clear), en (shift-enable), din, value, done.
module key_shifter
  import key_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [KEY_W-1:0] value,
  output logic             done
);

  localparam int CW = $clog2(KEY_W);
  localparam logic [CW-1:0] LAST = CW'(KEY_W - 1);

  logic [CW-1:0] cnt;

  // done is high in the same cycle the final bit is being accepted
  assign done = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      cnt   <= '0;
    end else if (en) begin
      value <= {value[KEY_W-2:0], din};
      cnt   <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_unlock_ctrl.sv
// Key unlock controller: serial key entry, compare, gated apply, lockout.
// Ports: start/abort/key_bit(_valid)/fsm_idle in; key_out, pulses, status out.
module key_unlock_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int               KEY_W      = KEY_W_DEF,
  parameter logic [KEY_W-1:0] GOLDEN_KEY = KEY_W'(GOLDEN_KEY_DEF),
  parameter int               MAX_FAIL   = MAX_FAIL_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              key_bit_valid,
  input  logic                              key_bit,
  input  logic                              fsm_idle,
  output logic [KEY_W-1:0]                  key_out,
  output logic                              key_applied,
  output logic                              fail,
  output logic                              lockout,
  output logic                              busy,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] MAXF = FW'(MAX_FAIL);

  key_state_t       state;
  logic [KEY_W-1:0] sr;
  logic             sh_done;
  logic             sh_clr;
  logic             sh_en;
  logic [FW-1:0]    fail_nxt;

  // abort wins over a valid bit in the same cycle
  assign sh_clr = (state == ST_IDLE) && start;
  assign sh_en  = (state == ST_SHIFT) && key_bit_valid && !abort;

  // saturating increment; the lockout path normally stops it first
  assign fail_nxt = (fail_cnt == MAXF) ? fail_cnt : fail_cnt + 1'b1;

  key_shifter #(
    .KEY_W(KEY_W)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .clr  (sh_clr),
    .en   (sh_en),
    .din  (key_bit),
    .value(sr),
    .done (sh_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      key_out     <= '0;
      key_applied <= 1'b0;
      fail        <= 1'b0;
      lockout     <= 1'b0;
      busy        <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      key_applied <= 1'b0;
      fail        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (sh_done) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sr == GOLDEN_KEY) begin
            state    <= ST_APPLY;
            fail_cnt <= '0;
          end else begin
            fail     <= 1'b1;
            fail_cnt <= fail_nxt;
            busy     <= 1'b0;
            if (fail_nxt == MAXF) begin
              state   <= ST_LOCKOUT;
              lockout <= 1'b1;
              key_out <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_APPLY: begin
          if (fsm_idle) begin
            key_out     <= sr;
            key_applied <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          key_out <= '0;
          lockout <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_unlock_ctrl.sv
// Scoreboard bench for key_unlock_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and checks them against the DUT outputs.
module tb_key_unlock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       key_bit_valid = 1'b0;
  logic       key_bit = 1'b0;
  logic       fsm_idle = 1'b1;
  logic [7:0] key_out;
  logic       key_applied;
  logic       fail;
  logic       lockout;
  logic       busy;
  logic [1:0] fail_cnt;

  key_unlock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .key_bit_valid(key_bit_valid),
    .key_bit      (key_bit),
    .fsm_idle     (fsm_idle),
    .key_out      (key_out),
    .key_applied  (key_applied),
    .fail         (fail),
    .lockout      (lockout),
    .busy         (busy),
    .fail_cnt     (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_apply;
    logic [7:0] key;
    logic [1:0] cnt;
    bit         lock;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // bench-side model of the visible state
  logic [7:0] m_key = 8'h00;
  int         m_cnt = 0;
  bit         m_lock = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (key_applied || fail)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, key_applied, fail}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_applied", {31'd0, key_applied}, {31'd0, e.is_apply});
        chk("pulse_fail", {31'd0, fail}, {31'd0, !e.is_apply});
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_key_out", {24'd0, key_out}, {24'd0, e.key});
        chk("pulse_fail_cnt", {30'd0, fail_cnt}, {30'd0, e.cnt});
        chk("pulse_lockout", {31'd0, lockout}, {31'd0, e.lock});
      end
    end
  end

  // update model and queue the pulse an entry of key k should produce
  task automatic expect_entry(input logic [7:0] k, input int at_apply,
                              input int at_fail);
    exp_t e;
    if (m_lock) return;
    if (k == 8'hA5) begin
      m_cnt = 0;
      m_key = k;
      e = '{1'b1, k, 2'd0, 1'b0, at_apply};
    end else begin
      if (m_cnt < 3) m_cnt++;
      if (m_cnt == 3) begin
        m_lock = 1'b1;
        m_key = 8'h00;
      end
      e = '{1'b0, m_key, m_cnt[1:0], m_lock, at_fail};
    end
    q.push_back(e);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // feeds nbits bits of k MSB first; returns cycle of last bit's drive
  task automatic feed(input logic [7:0] k, input int nbits, input bit gaps,
                      output int last);
    last = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      key_bit_valid = 1'b1;
      key_bit = k[i];
      last = cyc;
      @(negedge clk);
      key_bit_valid = 1'b0;
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic send_key(input logic [7:0] k, input bit gaps);
    int last;
    do_start();
    feed(k, 8, gaps, last);
    expect_entry(k, last + 3, last + 2);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_key_out"}, {24'd0, key_out}, {24'd0, m_key});
    chk({tag, "_fail_cnt"}, {30'd0, fail_cnt}, m_cnt);
    chk({tag, "_lockout"}, {31'd0, lockout}, {31'd0, m_lock});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_out"}, {24'd0, key_out}, 32'd0);
    chk({tag, "_applied"}, {31'd0, key_applied}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
    chk({tag, "_lockout"}, {31'd0, lockout}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_fail_cnt"}, {30'd0, fail_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_key = 8'h00;
    m_cnt = 0;
    m_lock = 1'b0;
    q.delete();
    chk_all_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int last;
    repeat (2) @(negedge clk);
    chk_all_zero("por");
    rst = 1'b0;

    // valid bits in IDLE must be ignored
    key_bit_valid = 1'b1;
    key_bit = 1'b1;
    repeat (3) @(negedge clk);
    key_bit_valid = 1'b0;
    chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

    send_key(8'hA5, 1'b0);
    drain();
    chk_idle_state("good1");

    send_key(8'hA4, 1'b0);
    drain();
    chk_idle_state("wrong1");

    send_key(8'hA5, 1'b0);
    drain();
    chk_idle_state("good2");

    // abort after 4 bits, with a valid bit in the same cycle
    send_key(8'h3C, 1'b0);
    drain();
    do_start();
    feed(8'hA5, 4, 1'b0, last);
    abort = 1'b1;
    key_bit_valid = 1'b1;
    key_bit = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    key_bit_valid = 1'b0;
    @(negedge clk);
    chk_idle_state("abort");

    send_key(8'hA5, 1'b1);
    drain();
    chk_idle_state("gaps");

    // reset in the middle of SHIFT
    do_start();
    feed(8'hA5, 3, 1'b0, last);
    do_reset();
    send_key(8'hA5, 1'b0);
    drain();
    chk_idle_state("after_mid_rst");

    // apply hold-off, from a freshly reset key_out
    do_reset();
    fsm_idle = 1'b0;
    do_start();
    feed(8'hA5, 8, 1'b0, last);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      chk("holdoff_busy", {31'd0, busy}, 32'd1);
      chk("holdoff_key_out", {24'd0, key_out}, 32'd0);
    end
    fsm_idle = 1'b1;
    expect_entry(8'hA5, cyc + 1, 0);
    drain();
    chk_idle_state("holdoff_done");

    // three consecutive wrong keys lock the block
    send_key(8'h00, 1'b0);
    drain();
    send_key(8'hFF, 1'b0);
    drain();
    chk_idle_state("two_wrong");
    send_key(8'h5A, 1'b0);
    drain();
    chk_idle_state("locked");
    send_key(8'hA5, 1'b0);
    repeat (6) @(negedge clk);
    drain();
    chk_idle_state("locked_ignore");

    do_reset();
    send_key(8'hA5, 1'b0);
    drain();
    chk_idle_state("unlocked");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cyc %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_unlock_ctrl.md
KEY_UNLOCK_CTRL -- requirements
Module: key_unlock_ctrl

Interface
REQ-001 The block SHALL have parameters: KEY_W, 8, key width in bits; GOLDEN_KEY, 8'hA5, correct key value; MAX_FAIL, 3, failed attempts before lockout.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset: clk input and rst input, both 1 bit.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a key-entry attempt
- abort  in  1  cancel the attempt in progress
- key_bit_valid  in  1  key_bit is valid this cycle
- key_bit  in  1  serial key bit, MSB first
- fsm_idle  in  1  controlled locked FSM is in its initial state
- key_out  out  KEY_W  key value driven to the locked FSM's key inputs
- key_applied  out  1  one-cycle pulse: key_out was updated
- fail  out  1  one-cycle pulse: attempt rejected
- lockout  out  1  permanent lockout level
- busy  out  1  attempt in progress
- fail_cnt  out  clog2(MAX_FAIL+1)  consecutive failed attempts

Function
REQ-004 The FSM SHALL have states IDLE, SHIFT, CHECK, APPLY and LOCKOUT.
REQ-005 IDLE: start=1 SHALL move to SHIFT and clear the shift register and bit counter; key_bit_valid in IDLE SHALL be ignored.
REQ-006 SHIFT: each cycle with key_bit_valid=1 SHALL shift the bit into the LSB (sr <= {sr[KEY_W-2:0], key_bit}) and increment the bit counter; the cycle accepting bit KEY_W-1 SHALL move to CHECK.
REQ-007 SHIFT: abort=1 SHALL return to IDLE with no fail pulse and no fail_cnt change; abort SHALL take priority over key_bit_valid in the same cycle.
REQ-008 CHECK SHALL last exactly one cycle. If sr==GOLDEN_KEY: move to APPLY and clear fail_cnt. Otherwise: increment fail_cnt and pulse fail in the next cycle; move to LOCKOUT when the new count equals MAX_FAIL, else to IDLE.
REQ-009 APPLY SHALL wait until fsm_idle=1, then load key_out <= sr, pulse key_applied for one cycle, and return to IDLE; abort in CHECK or APPLY SHALL be ignored.
REQ-010 LOCKOUT SHALL force key_out to all-zero, hold lockout=1, ignore all inputs, and be left only by rst.
REQ-011 key_out SHALL hold its value between successful applies; a failed attempt SHALL NOT alter key_out.
REQ-012 busy SHALL be 1 in SHIFT, CHECK and APPLY, and 0 otherwise; start while busy SHALL be ignored.
REQ-013 Latency: last bit accepted in cycle N -> CHECK in N+1 -> APPLY in N+2; with fsm_idle=1, key_out and key_applied SHALL be valid in N+3.
REQ-014 fail_cnt SHALL saturate at MAX_FAIL and never wrap.

Reset
REQ-015 rst=1 at a clock edge SHALL force state IDLE, key_out=0, key_applied=0, fail=0, lockout=0, busy=0, fail_cnt=0, shift register=0, bit counter=0, including mid-attempt and from LOCKOUT.

Structure
REQ-016 The state enumeration and the default KEY_W, GOLDEN_KEY and MAX_FAIL values SHALL reside in the shared package key_ctrl_pkg.
REQ-017 The shift register and bit counter SHALL be one sub-module, key_shifter (ports: load-clear, shift-enable, bit in, value out, done); all other logic SHALL stay in key_unlock_ctrl.

Verification
REQ-018 Correct entry: start, then bits 1,0,1,0,0,1,0,1 with fsm_idle=1 -> key_out=8'hA5 and key_applied pulse 3 cycles after the last bit; fail_cnt=0.
REQ-019 Wrong key: enter 8'hA4 -> fail pulse 2 cycles after the last bit, fail_cnt=1, key_out unchanged, state IDLE.
REQ-020 Lockout: three consecutive wrong keys -> lockout=1 and key_out=0; a subsequent correct entry is ignored; rst clears lockout and fail_cnt.
REQ-021 Apply hold-off: correct key with fsm_idle=0 for 5 cycles -> busy stays 1 and key_out stays old; key_out=8'hA5 the cycle after fsm_idle rises.
REQ-022 Abort/gaps: abort after 4 bits -> IDLE, fail_cnt unchanged; correct key with valid deasserted on alternate cycles -> still accepted.
REQ-023 Reset mid-SHIFT after 3 bits -> all outputs 0; a fresh full correct entry succeeds.
